// File: rtl/sys_ctrl.sv
// System controller: decodes synchronized UART command bytes into register-file
// accesses and ALU operations, and returns results byte-wise to the transmit path.
module sys_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ALU_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    input  logic [ALU_WIDTH-1:0]  alu_out,
    input  logic                  alu_valid,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [3:0]            alu_fun,
    output logic                  alu_en,
    output logic                  clk_gate_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B   = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_WAIT,
        SEND_RD,
        SEND_LO,
        SEND_HI
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] rd_cap;
    logic [ALU_WIDTH-1:0]  alu_cap;

    // Strobes default low each cycle; the clock gate trails the ALU states by one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            rd_cap      <= '0;
            alu_cap     <= '0;
            rf_addr     <= '0;
            rf_wr_data  <= '0;
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            alu_fun     <= 4'h0;
            alu_en      <= 1'b0;
            clk_gate_en <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
        end else begin
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            alu_en      <= 1'b0;
            tx_valid    <= 1'b0;
            clk_gate_en <= (state == ALU_FUN) || (state == ALU_WAIT);

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_WR:      state <= WR_ADDR;
                            CMD_RD:      state <= RD_ADDR;
                            CMD_ALU_OP:  state <= OP_A;
                            CMD_ALU_NOP: state <= ALU_FUN;
                            default:     state <= IDLE;
                        endcase
                    end
                end

                WR_ADDR: begin
                    if (rx_valid) begin
                        rf_addr <= rx_data[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (rx_valid) begin
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (rx_valid) begin
                        rf_addr  <= rx_data[ADDR_WIDTH-1:0];
                        rf_rd_en <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end

                // Bytes arriving while a response is outstanding are dropped.
                RD_WAIT: begin
                    if (rf_rd_valid) begin
                        rd_cap <= rf_rd_data;
                        state  <= SEND_RD;
                    end
                end

                OP_A: begin
                    if (rx_valid) begin
                        rf_addr    <= ADDR_OP_A;
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= OP_B;
                    end
                end

                OP_B: begin
                    if (rx_valid) begin
                        rf_addr    <= ADDR_OP_B;
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= ALU_FUN;
                    end
                end

                ALU_FUN: begin
                    if (rx_valid) begin
                        alu_fun <= rx_data[3:0];
                        alu_en  <= 1'b1;
                        state   <= ALU_WAIT;
                    end
                end

                ALU_WAIT: begin
                    if (alu_valid) begin
                        alu_cap <= alu_out;
                        state   <= SEND_LO;
                    end
                end

                SEND_RD: begin
                    if (!tx_busy) begin
                        tx_data  <= rd_cap;
                        tx_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end

                // ALU result leaves low byte first.
                SEND_LO: begin
                    if (!tx_busy) begin
                        tx_data  <= alu_cap[DATA_WIDTH-1:0];
                        tx_valid <= 1'b1;
                        state    <= SEND_HI;
                    end
                end

                SEND_HI: begin
                    if (!tx_busy) begin
                        tx_data  <= alu_cap[ALU_WIDTH-1 -: DATA_WIDTH];
                        tx_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: frame-level reference model compared every cycle, with
// register-file / ALU responders, directed scenarios and a randomized byte stream.
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  rf_rd_data = 8'h00;
    logic        rf_rd_valid = 1'b0;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        clk_gate_en;
    logic [7:0]  tx_data;
    logic        tx_valid;

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_out(alu_out), .alu_valid(alu_valid),
        .tx_busy(tx_busy),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
        .rf_rd_en(rf_rd_en), .alu_fun(alu_fun), .alu_en(alu_en),
        .clk_gate_en(clk_gate_en), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: register file and ALU responders ----------------
    logic [7:0]  regs [16];
    int          rd_cnt = 0, alu_cnt = 0;
    int          rd_delay = 0, alu_delay = 0;   // 0 selects a random latency
    logic [7:0]  rd_val = 8'h00;
    logic [15:0] alu_val = 16'h0000;
    logic [15:0] alu_forced = 16'h0000;
    bit          alu_force = 1'b0;
    bit          force_busy = 1'b0;
    bit          rand_busy = 1'b0;

    initial for (int i = 0; i < 16; i++) regs[i] = 8'h00;

    always @(negedge CLK) begin
        rf_rd_valid = 1'b0;
        alu_valid   = 1'b0;
        rf_rd_data  = 8'($urandom);
        alu_out     = 16'($urandom);
        if (RST) begin
            rd_cnt  = 0;
            alu_cnt = 0;
        end else begin
            if (rf_wr_en) regs[rf_addr] = rf_wr_data;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    rf_rd_valid = 1'b1;
                    rf_rd_data  = rd_val;
                end
            end
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    alu_valid = 1'b1;
                    alu_out   = alu_val;
                end
            end
            if (rf_rd_en) begin
                rd_cnt = (rd_delay != 0) ? rd_delay : int'($urandom_range(1, 5));
                rd_val = regs[rf_addr];
            end
            if (alu_en) begin
                alu_cnt = (alu_delay != 0) ? alu_delay : int'($urandom_range(1, 5));
                alu_val = alu_force ? alu_forced : 16'($urandom);
            end
        end
        tx_busy = force_busy ? 1'b1 : (rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0);
    end

    // ---------------- reference model: frames, outstanding response, tx byte queue ----------------
    logic [7:0] frame[$];
    logic [7:0] txq[$];
    bit         wait_rd = 1'b0, wait_alu = 1'b0, in_reset = 1'b1;
    logic [3:0] m_addr = 4'h0;
    bit         exp_wr_en, exp_rd_en, exp_alu_en, exp_tx_valid, exp_gate;
    logic [3:0] exp_addr, exp_fun;
    logic [7:0] exp_wdata, exp_txd;

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        exp_wr_en = 1'b1;
        exp_addr  = a;
        exp_wdata = d;
    endtask

    task automatic model_alu(input logic [7:0] f);
        exp_alu_en = 1'b1;
        exp_fun    = f[3:0];
        wait_alu   = 1'b1;
        frame.delete();
    endtask

    task automatic model_step();
        logic [7:0] last;
        int         n;
        exp_wr_en    = 1'b0;
        exp_rd_en    = 1'b0;
        exp_alu_en   = 1'b0;
        exp_tx_valid = 1'b0;
        if (RST) begin
            frame.delete();
            txq.delete();
            wait_rd  = 1'b0;
            wait_alu = 1'b0;
            exp_gate = 1'b0;
            in_reset = 1'b1;
        end else begin
            in_reset = 1'b0;
            // Gate is high one cycle after the controller is awaiting a func byte or ALU result.
            exp_gate = wait_alu || (frame.size() == 1 && frame[0] == 8'hDD)
                                || (frame.size() == 3 && frame[0] == 8'hCC);
            if (txq.size() > 0) begin
                if (!tx_busy) begin
                    exp_tx_valid = 1'b1;
                    exp_txd      = txq.pop_front();
                end
            end else if (wait_rd) begin
                if (rf_rd_valid) begin
                    txq.push_back(rf_rd_data);
                    wait_rd = 1'b0;
                end
            end else if (wait_alu) begin
                if (alu_valid) begin
                    txq.push_back(alu_out[7:0]);
                    txq.push_back(alu_out[15:8]);
                    wait_alu = 1'b0;
                end
            end else if (rx_valid) begin
                frame.push_back(rx_data);
                n    = frame.size();
                last = rx_data;
                case (frame[0])
                    8'hAA: begin
                        if (n == 2) m_addr = last[3:0];
                        else if (n == 3) begin
                            model_write(m_addr, last);
                            frame.delete();
                        end
                    end
                    8'hBB: begin
                        if (n == 2) begin
                            exp_rd_en = 1'b1;
                            exp_addr  = last[3:0];
                            wait_rd   = 1'b1;
                            frame.delete();
                        end
                    end
                    8'hCC: begin
                        if (n == 2) model_write(4'h0, last);
                        else if (n == 3) model_write(4'h1, last);
                        else if (n == 4) model_alu(last);
                    end
                    8'hDD: if (n == 2) model_alu(last);
                    default: frame.delete();
                endcase
            end
        end
    endtask

    // ---------------- per-cycle compare and observation logs ----------------
    logic [11:0] wr_log[$];
    logic [7:0]  tx_log[$];
    logic [3:0]  fun_log[$];
    int          rd_log = 0;
    int          gate_cnt = 0;

    always @(posedge CLK) begin
        model_step();
        #1;
        if (in_reset) begin
            check("reset rf_addr", 32'(rf_addr), 0);
            check("reset rf_wr_data", 32'(rf_wr_data), 0);
            check("reset rf_wr_en", 32'(rf_wr_en), 0);
            check("reset rf_rd_en", 32'(rf_rd_en), 0);
            check("reset alu_fun", 32'(alu_fun), 0);
            check("reset alu_en", 32'(alu_en), 0);
            check("reset clk_gate_en", 32'(clk_gate_en), 0);
            check("reset tx_data", 32'(tx_data), 0);
            check("reset tx_valid", 32'(tx_valid), 0);
        end else begin
            check("rf_wr_en", 32'(rf_wr_en), 32'(exp_wr_en));
            check("rf_rd_en", 32'(rf_rd_en), 32'(exp_rd_en));
            check("alu_en", 32'(alu_en), 32'(exp_alu_en));
            check("tx_valid", 32'(tx_valid), 32'(exp_tx_valid));
            check("clk_gate_en", 32'(clk_gate_en), 32'(exp_gate));
            if (exp_wr_en) begin
                check("wr rf_addr", 32'(rf_addr), 32'(exp_addr));
                check("wr rf_wr_data", 32'(rf_wr_data), 32'(exp_wdata));
            end
            if (exp_rd_en) check("rd rf_addr", 32'(rf_addr), 32'(exp_addr));
            if (exp_alu_en) check("alu_fun", 32'(alu_fun), 32'(exp_fun));
            if (exp_tx_valid) check("tx_data", 32'(tx_data), 32'(exp_txd));
        end
        if (rf_wr_en) wr_log.push_back({rf_addr, rf_wr_data});
        if (tx_valid) tx_log.push_back(tx_data);
        if (alu_en) fun_log.push_back(alu_fun);
        if (rf_rd_en) rd_log++;
        if (clk_gate_en) gate_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [7:0] b);
        @(negedge CLK);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge CLK);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        tx_log.delete();
        fun_log.delete();
        rd_log   = 0;
        gate_cnt = 0;
    endtask

    task automatic put_rand(input logic [7:0] b);
        quiet(int'($urandom_range(0, 2)));
        put(b);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        quiet(2);

        // Register write
        clear_logs();
        rd_delay = 3; alu_delay = 1;
        put(8'hAA); put(8'h05); put(8'h3C); quiet(3);
        check("write count", 32'(wr_log.size()), 1);
        if (wr_log.size() == 1) check("write addr/data", 32'(wr_log[0]), 32'h53C);

        // Register read, response 3 cycles later
        clear_logs();
        put(8'hBB); put(8'h05); quiet(10);
        check("read strobes", 32'(rd_log), 1);
        check("read tx count", 32'(tx_log.size()), 1);
        if (tx_log.size() == 1) check("read tx byte", 32'(tx_log[0]), 32'h3C);

        // ALU with operands
        clear_logs();
        alu_force = 1'b1; alu_forced = 16'h0046;
        put(8'hCC); put(8'h12); put(8'h34); put(8'h01); quiet(10);
        check("alu op writes", 32'(wr_log.size()), 2);
        if (wr_log.size() == 2) begin
            check("op A write", 32'(wr_log[0]), 32'h012);
            check("op B write", 32'(wr_log[1]), 32'h134);
        end
        check("alu_en count", 32'(fun_log.size()), 1);
        if (fun_log.size() == 1) check("alu_fun value", 32'(fun_log[0]), 1);
        check("alu tx count", 32'(tx_log.size()), 2);
        if (tx_log.size() == 2) begin
            check("alu tx low", 32'(tx_log[0]), 32'h46);
            check("alu tx high", 32'(tx_log[1]), 32'h00);
        end
        check("gate cycles", 32'(gate_cnt), 3);
        check("gate low after", 32'(clk_gate_en), 0);

        // tx_busy back-pressure
        clear_logs();
        alu_forced = 16'hBEEF; force_busy = 1'b1;
        put(8'hDD); put(8'h00); quiet(10);
        check("no tx while busy", 32'(tx_log.size()), 0);
        force_busy = 1'b0;
        quiet(6);
        check("busy tx count", 32'(tx_log.size()), 2);
        if (tx_log.size() == 2) begin
            check("busy tx low", 32'(tx_log[0]), 32'hEF);
            check("busy tx high", 32'(tx_log[1]), 32'hBE);
        end

        // Illegal byte in IDLE
        clear_logs();
        put(8'h55); quiet(3);
        check("junk activity", 32'(wr_log.size() + tx_log.size() + fun_log.size() + rd_log), 0);

        // Extra bytes while a read is outstanding
        clear_logs();
        rd_delay = 5;
        put(8'hBB); put(8'h05); put(8'hAA); put(8'h03); quiet(10);
        check("dropped-byte writes", 32'(wr_log.size()), 0);
        check("dropped-byte tx count", 32'(tx_log.size()), 1);
        if (tx_log.size() == 1) check("dropped-byte tx", 32'(tx_log[0]), 32'h3C);

        // Reset in the middle of a write frame
        put(8'hAA); put(8'h05); quiet(1);
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        clear_logs();
        put(8'hAA); put(8'h07); put(8'hA5); quiet(3);
        check("post-reset write count", 32'(wr_log.size()), 1);
        if (wr_log.size() == 1) check("post-reset write", 32'(wr_log[0]), 32'h7A5);

        // Randomized command stream
        rd_delay = 0; alu_delay = 0; alu_force = 1'b0; rand_busy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin put_rand(8'hAA); put_rand(8'($urandom)); put_rand(8'($urandom)); end
                2, 3: begin put_rand(8'hBB); put_rand(8'($urandom)); end
                4, 5: begin
                    put_rand(8'hCC); put_rand(8'($urandom));
                    put_rand(8'($urandom)); put_rand(8'($urandom));
                end
                6, 7: begin put_rand(8'hDD); put_rand(8'($urandom)); end
                8: put_rand(8'($urandom));
                default: repeat (3) put_rand(8'($urandom));
            endcase
            quiet(int'($urandom_range(0, 8)));
            if ($urandom_range(0, 49) == 0) begin
                quiet(1);
                @(negedge CLK); RST = 1'b1;
                @(negedge CLK); RST = 1'b0;
            end
        end

        // Drain outstanding responses within a bounded window
        rand_busy = 1'b0;
        quiet(1);
        k = 0;
        while ((wait_rd || wait_alu || txq.size() != 0) && k < 100) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (wait_rd || wait_alu || txq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: outstanding work after %0d cycles, expected none", k);
        end
        quiet(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
